// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MUL/DIV sequencer driving an external MUL32 and an internal restoring divider.
// Define MDU_DIV_EN to build the divider; without it DIV requests complete as illegal ops.
module mdu_ctrl #(
   parameter int MUL_WAIT = 2
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        i_start,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_mul_a,
   output logic [31:0] o_mul_b,
   input  logic [63:0] i_mul_p,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_dz,
   output logic        o_ill
);
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] mul_a_q, mul_b_q;
   logic [31:0] hi_q, lo_q;
   logic        ill_q;

`ifdef MDU_DIV_EN
   logic [31:0] quo_q, rem_q, dvs_q;
   logic        qneg_q, rneg_q, dz_q;
   logic [32:0] trial;

   // Trial subtract of the divisor from the partial remainder with the next dividend bit shifted in.
   assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
`endif

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               if (i_op == 2'b00)                     state_d = S_MUL;
`ifdef MDU_DIV_EN
               else if (i_op == 2'b01 && i_b != '0)   state_d = S_DIV;
`endif
               else                                   state_d = S_DONE;
            end
         end
         S_MUL:   if (cnt_q == '0) state_d = S_DONE;
`ifdef MDU_DIV_EN
         S_DIV:   if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state_q != S_IDLE);
      o_done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ill_q   <= 1'b0;
`ifdef MDU_DIV_EN
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  ill_q <= 1'b0;
`ifdef MDU_DIV_EN
                  dz_q  <= 1'b0;
`endif
                  if (i_op == 2'b00) begin
                     mul_a_q <= i_a;
                     mul_b_q <= i_b;
                     cnt_q   <= 5'(MUL_WAIT - 1);
                  end
`ifdef MDU_DIV_EN
                  else if (i_op == 2'b01) begin
                     if (i_b == '0) begin
                        dz_q <= 1'b1;
                        lo_q <= '1;
                        hi_q <= i_a;
                     end else begin
                        quo_q  <= i_a[31] ? (~i_a + 32'd1) : i_a;
                        dvs_q  <= i_b[31] ? (~i_b + 32'd1) : i_b;
                        rem_q  <= '0;
                        qneg_q <= i_a[31] ^ i_b[31];
                        rneg_q <= i_a[31];
                        cnt_q  <= 5'd31;
                     end
                  end
`endif
                  else begin
                     ill_q <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               if (cnt_q == '0) {hi_q, lo_q} <= i_mul_p;
               else             cnt_q <= cnt_q - 5'd1;
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
               if (!trial[32]) begin
                  rem_q <= trial[31:0];
                  quo_q <= {quo_q[30:0], 1'b1};
               end else begin
                  rem_q <= {rem_q[30:0], quo_q[31]};
                  quo_q <= {quo_q[30:0], 1'b0};
               end
               cnt_q <= cnt_q - 5'd1;
            end
            S_FIX: begin
               lo_q <= qneg_q ? (~quo_q + 32'd1) : quo_q;
               hi_q <= rneg_q ? (~rem_q + 32'd1) : rem_q;
            end
`endif
            default: ;
         endcase
      end
   end

   assign o_mul_a = mul_a_q;
   assign o_mul_b = mul_b_q;
   assign o_hi    = hi_q;
   assign o_lo    = lo_q;
   assign o_ill   = ill_q;
`ifdef MDU_DIV_EN
   assign o_dz    = dz_q;
`else
   assign o_dz    = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl; expectations adapt to whether MDU_DIV_EN is defined.
module tb_mdu_ctrl;
   localparam int MW = 2;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk, nRst, i_start;
   logic [1:0]  i_op;
   logic [31:0] i_a, i_b, o_mul_a, o_mul_b, o_hi, o_lo;
   logic [63:0] i_mul_p;
   logic        o_busy, o_done, o_dz, o_ill;

   mdu_ctrl #(.MUL_WAIT(MW)) dut (
      .clk(clk), .nRst(nRst), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
      .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_p(i_mul_p),
      .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo), .o_dz(o_dz), .o_ill(o_ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural MUL32: full signed 64-bit product of whatever the DUT presents.
   logic signed [63:0] ext_a, ext_b;
   always_comb begin
      ext_a   = {{32{o_mul_a[31]}}, o_mul_a};
      ext_b   = {{32{o_mul_b[31]}}, o_mul_b};
      i_mul_p = ext_a * ext_b;
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_hi = '0, exp_lo = '0;
   logic        exp_dz = 1'b0, exp_ill = 1'b0;
   int          exp_lat = 0;

   // Reference model: updates expected HI/LO/flags/latency from the operation's arithmetic meaning.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint la, lb, p, q, r;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      exp_dz  = 1'b0;
      exp_ill = 1'b0;
      if (op == 2'b00) begin
         p = la * lb;
         exp_hi = p[63:32];
         exp_lo = p[31:0];
         exp_lat = MW + 1;
      end else if (op == 2'b01 && DIV_EN) begin
         if (b == 32'd0) begin
            exp_lo = 32'hFFFF_FFFF;
            exp_hi = a;
            exp_dz = 1'b1;
            exp_lat = 1;
         end else begin
            q = la / lb;
            r = la % lb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
            exp_lat = 34;
         end
      end else begin
         exp_ill = 1'b1;
         exp_lat = 1;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issues one request (start sampled at edge T) and returns at the negedge of the done cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(negedge clk);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      @(negedge clk);
      i_start = 1'b0; i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         if (o_done) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      nRst = 1'b0; i_start = 1'b0; i_op = 2'b00; i_a = $urandom; i_b = $urandom;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({o_busy, o_done, o_hi, o_lo, o_mul_a, o_mul_b, o_dz, o_ill} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b hi=%h lo=%h ma=%h mb=%h dz=%b ill=%b, required all 0",
                  o_busy, o_done, o_hi, o_lo, o_mul_a, o_mul_b, o_dz, o_ill);
      end
      nRst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({o_busy, o_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
      end
      $display("txn reset hi=%h lo=%h busy=%b", o_hi, o_lo, o_busy);
   endtask

   task automatic test_mul();
      logic [31:0] ta[2], tb_[2], th[2], tl[2];
      int lat;
      ta[0] = 32'h8000_0000; tb_[0] = 32'h8000_0000; th[0] = 32'h4000_0000; tl[0] = 32'h0000_0000;
      ta[1] = 32'h8000_0000; tb_[1] = 32'h7FFF_FFFF; th[1] = 32'hC000_0000; tl[1] = 32'h8000_0000;
      for (int i = 0; i < 2; i++) begin
         run_op(2'b00, ta[i], tb_[i], lat);
         $display("txn mul a=%h b=%h lat=%0d hi=%h lo=%h", ta[i], tb_[i], lat, o_hi, o_lo);
         n_checks++;
         if (lat !== MW + 1) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d, required %0d", lat, MW + 1);
         end
         n_checks++;
         if ({o_hi, o_lo, o_dz, o_ill, o_busy} !== {th[i], tl[i], 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mul_result: hi=%h lo=%h dz=%b ill=%b busy=%b, required hi=%h lo=%h dz=0 ill=0 busy=1",
                     o_hi, o_lo, o_dz, o_ill, o_busy, th[i], tl[i]);
         end
         n_checks++;
         if ({o_mul_a, o_mul_b} !== {ta[i], tb_[i]}) begin
            n_fail++;
            $display("FAIL mul_operand_hold: a=%h b=%h, required a=%h b=%h", o_mul_a, o_mul_b, ta[i], tb_[i]);
         end
         exp_hi = th[i]; exp_lo = tl[i];
      end
   endtask

   task automatic test_mul_sweep();
      logic [31:0] a, b;
      int lat, bad;
      bad = 0;
      for (int i = 1; i <= 10000; i++) begin
         a = pick(); b = pick();
         model(2'b00, a, b);
         run_op(2'b00, a, b, lat);
         n_checks++;
         if (lat !== exp_lat || {o_hi, o_lo, o_dz, o_ill} !== {exp_hi, exp_lo, exp_dz, exp_ill}) begin
            n_fail++; bad++;
            $display("FAIL mul_sweep: a=%h b=%h lat=%0d hi=%h lo=%h, required lat=%0d hi=%h lo=%h",
                     a, b, lat, o_hi, o_lo, exp_lat, exp_hi, exp_lo);
         end
         if (i % 1000 == 0) $display("txn mul_sweep batch=%0d bad=%0d", i / 1000, bad);
      end
   endtask

   task automatic test_div();
      logic [31:0] ta[3], tb_[3], th[3], tl[3];
      logic [31:0] a, b;
      int lat;
      ta[0] = 32'hFFFF_FFF9; tb_[0] = 32'h0000_0002; th[0] = 32'hFFFF_FFFF; tl[0] = 32'hFFFF_FFFD;
      ta[1] = 32'h8000_0000; tb_[1] = 32'hFFFF_FFFF; th[1] = 32'h0000_0000; tl[1] = 32'h8000_0000;
      ta[2] = 32'h0000_0009; tb_[2] = 32'h0000_0003; th[2] = 32'h0000_0000; tl[2] = 32'h0000_0003;
      for (int i = 0; i < 3; i++) begin
`ifdef MDU_DIV_EN
         exp_lat = 34; exp_hi = th[i]; exp_lo = tl[i]; exp_dz = 1'b0; exp_ill = 1'b0;
`else
         exp_lat = 1; exp_dz = 1'b0; exp_ill = 1'b1;
`endif
         run_op(2'b01, ta[i], tb_[i], lat);
         $display("txn div a=%h b=%h lat=%0d hi=%h lo=%h ill=%b", ta[i], tb_[i], lat, o_hi, o_lo, o_ill);
         n_checks++;
         if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL div_latency: got %0d, required %0d", lat, exp_lat);
         end
         n_checks++;
         if ({o_hi, o_lo, o_dz, o_ill} !== {exp_hi, exp_lo, exp_dz, exp_ill}) begin
            n_fail++;
            $display("FAIL div_result: hi=%h lo=%h dz=%b ill=%b, required hi=%h lo=%h dz=%b ill=%b",
                     o_hi, o_lo, o_dz, o_ill, exp_hi, exp_lo, exp_dz, exp_ill);
         end
      end
      for (int i = 0; i < 30; i++) begin
         a = pick();
         b = (i % 3 == 0) ? 32'($urandom_range(1, 17)) : pick();
         if (b == 32'd0) b = 32'hFFFF_FFF3;
         model(2'b01, a, b);
         run_op(2'b01, a, b, lat);
         $display("txn div a=%h b=%h lat=%0d hi=%h lo=%h", a, b, lat, o_hi, o_lo);
         n_checks++;
         if (lat !== exp_lat || {o_hi, o_lo, o_dz, o_ill} !== {exp_hi, exp_lo, exp_dz, exp_ill}) begin
            n_fail++;
            $display("FAIL div_random: a=%h b=%h lat=%0d hi=%h lo=%h ill=%b, required lat=%0d hi=%h lo=%h ill=%b",
                     a, b, lat, o_hi, o_lo, o_ill, exp_lat, exp_hi, exp_lo, exp_ill);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] a;
      int lat;
      for (int i = 0; i < 3; i++) begin
         a = (i == 0) ? 32'd5 : pick();
         model(2'b01, a, 32'd0);
         run_op(2'b01, a, 32'd0, lat);
         $display("txn divz a=%h lat=%0d hi=%h lo=%h dz=%b ill=%b", a, lat, o_hi, o_lo, o_dz, o_ill);
         n_checks++;
         if (lat !== 1) begin
            n_fail++;
            $display("FAIL divz_latency: got %0d, required 1", lat);
         end
         n_checks++;
         if ({o_hi, o_lo, o_dz, o_ill} !== {exp_hi, exp_lo, exp_dz, exp_ill}) begin
            n_fail++;
            $display("FAIL divz_result: hi=%h lo=%h dz=%b ill=%b, required hi=%h lo=%h dz=%b ill=%b",
                     o_hi, o_lo, o_dz, o_ill, exp_hi, exp_lo, exp_dz, exp_ill);
         end
      end
   endtask

   task automatic test_illegal();
      logic [1:0] ops[4];
      logic [31:0] a, b;
      int lat;
      ops[0] = 2'b00; ops[1] = 2'b10; ops[2] = 2'b11; ops[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         a = $urandom | 32'h0000_0010; b = $urandom | 32'h0000_0001;
         model(ops[i], a, b);
         run_op(ops[i], a, b, lat);
         $display("txn op=%b a=%h b=%h lat=%0d hi=%h lo=%h ill=%b", ops[i], a, b, lat, o_hi, o_lo, o_ill);
         n_checks++;
         if (lat !== exp_lat || {o_hi, o_lo, o_dz, o_ill} !== {exp_hi, exp_lo, exp_dz, exp_ill}) begin
            n_fail++;
            $display("FAIL illegal_op: op=%b lat=%0d hi=%h lo=%h ill=%b, required lat=%0d hi=%h lo=%h ill=%b",
                     ops[i], lat, o_hi, o_lo, o_ill, exp_lat, exp_hi, exp_lo, exp_ill);
         end
      end
   endtask

   // A second start pulsed while busy (or in the done cycle) must be dropped entirely.
   task automatic busy_case(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int pulse_k);
      int n_done, first_k;
      logic [31:0] got_hi, got_lo;
      model(op, a, b);
      n_done = 0; first_k = -1; got_hi = '0; got_lo = '0;
      @(negedge clk);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      @(negedge clk);
      for (int k = 1; k <= 60; k++) begin
         if (o_done) begin
            n_done++;
            if (first_k < 0) begin
               first_k = k; got_hi = o_hi; got_lo = o_lo;
            end
         end
         i_start = (k == pulse_k);
         i_op = 2'b00; i_a = $urandom; i_b = $urandom;
         @(negedge clk);
      end
      i_start = 1'b0;
      $display("txn busy op=%b pulse=%0d dones=%0d at=%0d hi=%h lo=%h", op, pulse_k, n_done, first_k, got_hi, got_lo);
      n_checks++;
      if (n_done !== 1 || first_k !== exp_lat) begin
         n_fail++;
         $display("FAIL busy_ignore_done: dones=%0d at=%0d, required 1 at %0d", n_done, first_k, exp_lat);
      end
      n_checks++;
      if ({got_hi, got_lo, o_busy} !== {exp_hi, exp_lo, 1'b0}) begin
         n_fail++;
         $display("FAIL busy_ignore_result: hi=%h lo=%h busy=%b, required hi=%h lo=%h busy=0",
                  got_hi, got_lo, o_busy, exp_hi, exp_lo);
      end
   endtask

   task automatic test_back_to_back();
      busy_case(2'b00, $urandom, $urandom, 2);
      busy_case(2'b00, $urandom, $urandom, MW + 1);
`ifdef MDU_DIV_EN
      busy_case(2'b01, 32'hFFFF_FFF9, 32'd2, 5);
`endif
   endtask

   task automatic abort_case(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int abort_k);
      int lat, n_done;
      run_op(2'b00, 32'd3, 32'd5, lat);
      @(negedge clk);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      @(negedge clk);
      i_start = 1'b0;
      for (int k = 1; k < abort_k; k++) @(negedge clk);
      nRst = 1'b0;
      #1;
      n_checks++;
      if ({o_busy, o_done, o_hi, o_lo, o_dz, o_ill} !== '0) begin
         n_fail++;
         $display("FAIL reset_abort_state: busy=%b done=%b hi=%h lo=%h dz=%b ill=%b, required all 0",
                  o_busy, o_done, o_hi, o_lo, o_dz, o_ill);
      end
      @(negedge clk);
      nRst = 1'b1;
      n_done = 0;
      for (int k = 0; k < 50; k++) begin
         if (o_done || o_busy) n_done++;
         @(negedge clk);
      end
      $display("txn abort op=%b at=%0d activity=%0d hi=%h lo=%h", op, abort_k, n_done, o_hi, o_lo);
      n_checks++;
      if (n_done !== 0) begin
         n_fail++;
         $display("FAIL reset_abort_no_done: busy/done cycles=%0d, required 0", n_done);
      end
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_reset_abort();
      abort_case(2'b00, $urandom, $urandom, 2);
`ifdef MDU_DIV_EN
      abort_case(2'b01, 32'hFFFF_FFF9, 32'd2, 10);
`endif
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      test_mul_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
